min_max_seq: RTL

MIN_MAX_SEQ -- requirements
Module: min_max_seq

---
 rtl/min_max_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/min_max_seq.sv
// min_max_seq: LED bargraph showing val_r inside a [min_r, max_r] window.
// The span above val_r up to max_r blinks with period 2*BLINK_DIV cycles.
// com_i picks the display mode: 00 window, 01 linear, 10 all off, 11 all on.
// Optional feature: define MIN_MAX_PEAK_HOLD_EN to add a peak-hold marker in mode 00.
module min_max_seq #(
  parameter int unsigned VALSIZE   = 4,
  parameter int unsigned BLINK_DIV = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              com_i,
  input  logic [VALSIZE-1:0]      min_i,
  input  logic [VALSIZE-1:0]      max_i,
  input  logic                    load_i,
  input  logic [VALSIZE-1:0]      val_i,
  input  logic                    val_valid_i,
  output logic [(2**VALSIZE)-1:0] leds_o,
  output logic                    cfg_err_o
);

  localparam int unsigned LEDS = 2 ** VALSIZE;
  localparam int unsigned CW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [VALSIZE-1:0] min_r;
  logic [VALSIZE-1:0] max_r;
  logic [VALSIZE-1:0] val_r;
  logic [CW-1:0]      cnt_r;
  logic               osc_r;
  logic [LEDS-1:0]    leds_nxt;
  logic               load_ok;

  // Widened copies so index compares never wrap at val_r = 2**VALSIZE-1
  logic [VALSIZE:0]   idx;
  logic [VALSIZE:0]   min_x;
  logic [VALSIZE:0]   max_x;
  logic [VALSIZE:0]   val_x;
  logic               in_win;

`ifdef MIN_MAX_PEAK_HOLD_EN
  logic [VALSIZE-1:0] peak_r;
`endif

  assign load_ok = load_i && (min_i <= max_i);

  // Bounds, value, blink oscillator and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_r     <= '0;
      max_r     <= '1;
      val_r     <= '0;
      cnt_r     <= '0;
      osc_r     <= 1'b1;
      leds_o    <= '0;
      cfg_err_o <= 1'b0;
    end else begin
      if (load_ok) begin
        min_r <= min_i;
        max_r <= max_i;
      end
      cfg_err_o <= load_i && (min_i > max_i);
      if (val_valid_i) begin
        val_r <= val_i;
      end
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
        osc_r <= ~osc_r;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
      leds_o <= leds_nxt;
    end
  end

`ifdef MIN_MAX_PEAK_HOLD_EN
  // Peak hold: restarts from val_i on an accepted load, otherwise follows the largest valid value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      peak_r <= '0;
    end else if (load_ok) begin
      peak_r <= val_i;
    end else if (val_valid_i && (val_i > peak_r)) begin
      peak_r <= val_i;
    end
  end
`endif

  // Next LED pattern from the registered state and the live mode select
  always_comb begin
    leds_nxt = '0;
    idx      = '0;
    min_x    = {1'b0, min_r};
    max_x    = {1'b0, max_r};
    val_x    = {1'b0, val_r};
    in_win   = (min_x <= val_x) && (val_x <= max_x);
    case (com_i)
      2'b00: begin
        if (in_win) begin
          for (int unsigned i = 0; i < LEDS; i++) begin
            idx = i[VALSIZE:0];
            if ((idx >= min_x) && (idx <= val_x)) begin
              leds_nxt[i] = 1'b1;
            end else if ((idx > val_x) && (idx <= max_x)) begin
              leds_nxt[i] = osc_r;
            end
          end
        end
`ifdef MIN_MAX_PEAK_HOLD_EN
        if ((peak_r >= min_r) && (peak_r <= max_r)) begin
          leds_nxt[peak_r] = 1'b1;
        end
`endif
      end
      2'b01: begin
        for (int unsigned i = 0; i < LEDS; i++) begin
          idx = i[VALSIZE:0];
          if (idx <= val_x) begin
            leds_nxt[i] = 1'b1;
          end
        end
      end
      2'b10: leds_nxt = '0;
      default: leds_nxt = '1;
    endcase
  end

endmodule
